addsub_accumulator: RTL and testbench

//  Sequential front end for adder_subtractor: a W-bit accumulator that takes one operation per

---
 rtl/addsub_pkg.sv | 33 +++
 rtl/addsub_if.sv | 28 ++
 rtl/adder_subtractor.sv | 20 ++
 rtl/addsub_accumulator.sv | 85 ++++++++
 tb/tb_addsub_accumulator.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator.
// Opcode encoding, default width, output state and saturation limits.
package addsub_pkg;

    localparam int W_DEF = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Clamp value for an overflowing op; a_msb gives the signed direction.
    function automatic logic [W_DEF-1:0] sat_limit(
        input logic sub,
        input logic u,
        input logic a_msb
    );
        logic [W_DEF-1:0] lim;
        if (u) begin
            lim = sub ? {W_DEF{1'b0}} : {W_DEF{1'b1}};
        end else begin
            lim = a_msb ? {1'b1, {(W_DEF-1){1'b0}}}
                        : {1'b0, {(W_DEF-1){1'b1}}};
        end
        return lim;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operation/result handshake bundle of the accumulator.
// master = operand source and result consumer, slave = accumulator.
interface addsub_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     operand;
    logic             u;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     res;
    logic             v;
    logic             v_sticky;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        output in_valid, op, operand, u, out_ready,
        input  in_ready, out_valid, res, v, v_sticky, op_cnt
    );

    modport slave (
        input  in_valid, op, operand, u, out_ready,
        output in_ready, out_valid, res, v, v_sticky, op_cnt
    );
endinterface

// File: rtl/adder_subtractor.sv
// 4-bit combinational adder/subtractor with mode-dependent overflow.
// Unsigned: carry (add) or borrow (sub); signed: two's-complement overflow.
module adder_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       u,
    output logic [3:0] s,
    output logic       v
);
    logic [3:0] bx;
    logic [4:0] sum;
    logic       s_ov;

    assign bx   = b ^ {4{sub}};
    assign sum  = {1'b0, a} + {1'b0, bx} + {4'b0000, sub};
    assign s    = sum[3:0];
    assign s_ov = (a[3] == bx[3]) & (sum[3] != a[3]);
    assign v    = u ? (sum[4] ^ sub) : s_ov;
endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator front end: one op per valid/ready beat, result one cycle later.
// Tracks sticky overflow and a saturating count of ADD/SUB ops.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int CNT_W  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    addsub_if.slave bus
);
    if (W != 4) begin : g_bad_w
        $error("addsub_accumulator: W must be 4");
    end

    state_t           state;
    logic [W-1:0]     acc;
    logic             v_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             sub;
    logic [3:0]       alu_s;
    logic             alu_v;
    logic [W-1:0]     arith;

    assign sub = (bus.op == OP_SUB);

    adder_subtractor u_alu (
        .a   (acc),
        .b   (bus.operand),
        .sub (sub),
        .u   (bus.u),
        .s   (alu_s),
        .v   (alu_v)
    );

    assign arith = (SAT_EN && alu_v) ? sat_limit(sub, bus.u, acc[W-1])
                                     : alu_s;

    assign bus.in_ready  = (state == EMPTY) | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == FULL);
    assign bus.res       = acc;
    assign bus.v         = v_q;
    assign bus.v_sticky  = sticky_q;
    assign bus.op_cnt    = cnt_q;

    // Output register, flags, counter and EMPTY/FULL state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            acc      <= '0;
            v_q      <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            state <= FULL;
            unique case (bus.op)
                OP_LOAD: begin
                    acc <= bus.operand;
                    v_q <= 1'b0;
                end
                OP_CLR: begin
                    acc      <= '0;
                    v_q      <= 1'b0;
                    sticky_q <= 1'b0;
                    cnt_q    <= '0;
                end
                default: begin
                    acc      <= arith;
                    v_q      <= alu_v;
                    sticky_q <= sticky_q | alu_v;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end else if (bus.out_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench: wrap (SAT_EN=0) and saturating (SAT_EN=1) accumulators on
// identical stimulus, checked against an integer-arithmetic model.
module tb_addsub_accumulator;
    import addsub_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    addsub_if #(.W(4), .CNT_W(8)) ia ();
    addsub_if #(.W(4), .CNT_W(8)) ib ();

    assign ib.in_valid  = ia.in_valid;
    assign ib.op        = ia.op;
    assign ib.operand   = ia.operand;
    assign ib.u         = ia.u;
    assign ib.out_ready = ia.out_ready;

    addsub_accumulator #(.W(4), .CNT_W(8), .SAT_EN(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    addsub_accumulator #(.W(4), .CNT_W(8), .SAT_EN(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    int nvec = 0;
    int nerr = 0;

    int m_acc[2];
    int m_v[2];
    int m_st[2];
    int m_cnt[2];
    int m_ov;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0;
            m_v[d]   = 0;
            m_st[d]  = 0;
            m_cnt[d] = 0;
        end
        m_ov = 0;
    endfunction

    // True-result arithmetic, then clamp or wrap into 4 bits.
    function automatic void mdl(int d, int op, int b, int u);
        int a, r, sa, sb;
        bit ovf;
        a = m_acc[d];
        case (op)
            0: begin
                m_acc[d] = b;
                m_v[d]   = 0;
            end
            3: begin
                m_acc[d] = 0;
                m_v[d]   = 0;
                m_st[d]  = 0;
                m_cnt[d] = 0;
            end
            default: begin
                if (u != 0) begin
                    r   = (op == 1) ? a + b : a - b;
                    ovf = (r < 0) || (r > 15);
                    if (d == 1 && ovf) r = (r < 0) ? 0 : 15;
                end else begin
                    sa  = (a >= 8) ? a - 16 : a;
                    sb  = (b >= 8) ? b - 16 : b;
                    r   = (op == 1) ? sa + sb : sa - sb;
                    ovf = (r > 7) || (r < -8);
                    if (d == 1 && ovf) r = (r > 7) ? 7 : -8;
                end
                m_acc[d] = r & 15;
                m_v[d]   = ovf ? 1 : 0;
                if (ovf) m_st[d] = 1;
                if (m_cnt[d] < 255) m_cnt[d]++;
            end
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ov0"}, 32'(ia.out_valid), 32'(m_ov));
        chk({tag, "_ov1"}, 32'(ib.out_valid), 32'(m_ov));
        chk({tag, "_res0"}, 32'(ia.res), 32'(m_acc[0]));
        chk({tag, "_res1"}, 32'(ib.res), 32'(m_acc[1]));
        chk({tag, "_v0"}, 32'(ia.v), 32'(m_v[0]));
        chk({tag, "_v1"}, 32'(ib.v), 32'(m_v[1]));
        chk({tag, "_st0"}, 32'(ia.v_sticky), 32'(m_st[0]));
        chk({tag, "_st1"}, 32'(ib.v_sticky), 32'(m_st[1]));
        chk({tag, "_cnt0"}, 32'(ia.op_cnt), 32'(m_cnt[0]));
        chk({tag, "_cnt1"}, 32'(ib.op_cnt), 32'(m_cnt[1]));
    endtask

    task automatic cyc(input int valid, input int op, input int b,
                       input int u, input int ordy);
        logic [31:0] tmp;
        bit acc_now;
        @(negedge clk);
        tmp          = 32'(op);
        ia.op        = tmp[1:0];
        tmp          = 32'(b);
        ia.operand   = tmp[3:0];
        ia.u         = (u != 0);
        ia.in_valid  = (valid != 0);
        ia.out_ready = (ordy != 0);
        #1;
        acc_now = (valid != 0) && (m_ov == 0 || ordy != 0);
        chk("in_ready0", 32'(ia.in_ready), 32'(m_ov == 0 || ordy != 0));
        chk("in_ready1", 32'(ib.in_ready), 32'(m_ov == 0 || ordy != 0));
        @(posedge clk);
        #1;
        if (acc_now) begin
            mdl(0, op, b, u);
            mdl(1, op, b, u);
            m_ov = 1;
        end else if (ordy != 0) begin
            m_ov = 0;
        end
        check_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b1;
        ia.in_valid  = 1'b0;
        ia.op        = OP_LOAD;
        ia.operand   = 4'd0;
        ia.u         = 1'b1;
        ia.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("init_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(ia.in_ready), 32'd1);

        // unsigned, wrapping
        cyc(1, 0, 9, 1, 1);
        cyc(1, 1, 6, 1, 1);
        chk("u_add_15", 32'(ia.res), 32'd15);
        cyc(1, 1, 1, 1, 1);
        chk("u_wrap_res", 32'(ia.res), 32'd0);
        chk("u_wrap_v", 32'(ia.v), 32'd1);
        chk("u_wrap_st", 32'(ia.v_sticky), 32'd1);
        chk("u_wrap_cnt", 32'(ia.op_cnt), 32'd2);
        chk("u_sat_res", 32'(ib.res), 32'd15);
        cyc(1, 0, 3, 1, 1);
        cyc(1, 2, 5, 1, 1);
        chk("u_sub_res", 32'(ia.res), 32'd14);
        chk("u_sub_sat", 32'(ib.res), 32'd0);

        // signed
        cyc(1, 0, 7, 0, 1);
        cyc(1, 1, 1, 0, 1);
        chk("s_add_res", 32'(ia.res), 32'd8);
        chk("s_add_sat", 32'(ib.res), 32'd7);
        chk("s_add_v", 32'(ib.v), 32'd1);
        cyc(1, 0, 8, 0, 1);
        cyc(1, 2, 1, 0, 1);
        chk("s_sub_res", 32'(ia.res), 32'd7);
        chk("s_sub_sat", 32'(ib.res), 32'd8);
        cyc(1, 0, 2, 0, 1);
        cyc(1, 1, 14, 0, 1);
        chk("s_neg_res", 32'(ia.res), 32'd0);
        chk("s_neg_v", 32'(ia.v), 32'd0);
        cyc(1, 0, 12, 1, 1);
        cyc(1, 1, 9, 1, 1);
        chk("u_sat_hi", 32'(ib.res), 32'd15);
        cyc(0, 0, 0, 0, 1);

        // backpressure
        cyc(1, 0, 5, 1, 0);
        chk("bp_rdy_low", 32'(ia.in_ready), 32'd0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 0);
        chk("bp_hold", 32'(ia.res), 32'd5);
        cyc(1, 1, 1, 1, 1);
        chk("bp_release", 32'(ia.res), 32'd6);
        for (int i = 0; i < 6; i++) cyc(1, 1, i, 1, 1);
        cyc(0, 0, 0, 0, 1);

        // CLR after an overflow
        cyc(1, 0, 15, 1, 1);
        cyc(1, 1, 3, 1, 1);
        cyc(1, 3, 0, 0, 1);
        chk("clr_res", 32'(ia.res), 32'd0);
        chk("clr_st", 32'(ia.v_sticky), 32'd0);
        chk("clr_cnt", 32'(ia.op_cnt), 32'd0);
        chk("clr_ov", 32'(ia.out_valid), 32'd1);

        // counter saturation
        for (int i = 0; i < 260; i++) cyc(1, 1, 0, 1, 1);
        chk("cnt_sat", 32'(ia.op_cnt), 32'd255);

        // reset while a result is held
        cyc(1, 0, 9, 1, 0);
        ia.in_valid = 1'b0;
        do_reset();
        chk("mid_rst_rdy", 32'(ia.in_ready), 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
